lanectrl_dly_seq: RTL

LANECTRL_DLY_SEQ -- requirements
Module: lanectrl_dly_seq

---
 rtl/lanectrl_dly_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lanectrl_dly_seq.sv
`timescale 1ns/1ps
// lanectrl_dly_seq
//   Sequences one delay-line request against the lane controller. The
//   high-speed I/O clock is paused around the action, then the request
//   performs either a single LOAD pulse or a train of MOVE pulses.
//   A one-cycle DONE pulse (with ERR) reports completion.
//
// Ports
//   FAB_CLK, ARST_N          : clock, async active-low reset
//   REQ_VALID/REQ_READY      : request handshake (READY = idle)
//   REQ_OP/SEL/DIR/STEPS     : op (00 move, 01 load, 1x reserved), line, dir, taps
//   DELAY_LINE_*             : lane-controller delay-line controls
//   HS_IO_CLK_PAUSE          : high-speed clock pause
//   RX_OOR, TX_OOR           : out-of-range flags from the lane controller
//   BUSY, DONE, ERR          : status; DONE/ERR pulse together
//   STEPS_DONE               : move pulses issued for the last request
//
// All outputs are registered. Each transition loads the outputs that
// belong to the state being entered.
module lanectrl_dly_seq #(
  parameter int PAUSE_SETUP = 3,
  parameter int MOVE_GAP    = 2,
  parameter int PAUSE_HOLD  = 3
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_OP,
  input  logic       REQ_SEL,
  input  logic       REQ_DIR,
  input  logic [7:0] REQ_STEPS,
  output logic       DELAY_LINE_SEL,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       HS_IO_CLK_PAUSE,
  input  logic       RX_OOR,
  input  logic       TX_OOR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] STEPS_DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_LOAD, S_MOVE, S_GAP, S_HOLD, S_RESP
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       sel;
    logic [7:0] steps;
  } req_t;

  // counters hold "cycles remaining minus one" for the timed states
  localparam logic [3:0] SETUP_M1 = 4'(PAUSE_SETUP - 1);
  localparam logic [3:0] GAP_M1   = 4'(MOVE_GAP - 1);
  localparam logic [3:0] HOLD_M1  = 4'(PAUSE_HOLD - 1);

  state_t     state;
  req_t       req;
  logic [3:0] cnt;
  logic       err_flag;
  logic       oor;

  // only the flag of the line being adjusted matters
  assign oor = req.sel ? TX_OOR : RX_OOR;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                <= S_IDLE;
      req                  <= '0;
      cnt                  <= '0;
      err_flag             <= 1'b0;
      REQ_READY            <= 1'b1;
      BUSY                 <= 1'b0;
      DONE                 <= 1'b0;
      ERR                  <= 1'b0;
      HS_IO_CLK_PAUSE      <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      STEPS_DONE           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            req.op               <= REQ_OP;
            req.sel              <= REQ_SEL;
            req.steps            <= REQ_STEPS;
            DELAY_LINE_SEL       <= REQ_SEL;
            DELAY_LINE_DIRECTION <= REQ_DIR;
            STEPS_DONE           <= '0;
            REQ_READY            <= 1'b0;
            BUSY                 <= 1'b1;
            if (REQ_OP[1]) begin
              // reserved op: straight to the response, no pause
              state <= S_RESP;
              DONE  <= 1'b1;
              ERR   <= 1'b1;
            end else begin
              state           <= S_PAUSE;
              HS_IO_CLK_PAUSE <= 1'b1;
              cnt             <= SETUP_M1;
            end
          end
        end

        S_PAUSE: begin
          if (cnt == '0) begin
            if (req.op[0]) begin
              state           <= S_LOAD;
              DELAY_LINE_LOAD <= 1'b1;
            end else if (req.steps == '0) begin
              state <= S_HOLD;
              cnt   <= HOLD_M1;
            end else begin
              state           <= S_MOVE;
              DELAY_LINE_MOVE <= 1'b1;
              STEPS_DONE      <= STEPS_DONE + 8'd1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_LOAD: begin
          DELAY_LINE_LOAD <= 1'b0;
          if (oor) err_flag <= 1'b1;
          state <= S_HOLD;
          cnt   <= HOLD_M1;
        end

        S_MOVE: begin
          DELAY_LINE_MOVE <= 1'b0;
          // STEPS_DONE already counts the pulse now on the wire
          if (STEPS_DONE == req.steps) begin
            state <= S_HOLD;
            cnt   <= HOLD_M1;
          end else begin
            state <= S_GAP;
            cnt   <= GAP_M1;
          end
        end

        S_GAP: begin
          if (oor) begin
            err_flag <= 1'b1;
            state    <= S_HOLD;
            cnt      <= HOLD_M1;
          end else if (cnt == '0) begin
            state           <= S_MOVE;
            DELAY_LINE_MOVE <= 1'b1;
            STEPS_DONE      <= STEPS_DONE + 8'd1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_HOLD: begin
          if (cnt == '0) begin
            state           <= S_RESP;
            HS_IO_CLK_PAUSE <= 1'b0;
            DONE            <= 1'b1;
            ERR             <= err_flag;
            err_flag        <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_RESP: begin
          state     <= S_IDLE;
          DONE      <= 1'b0;
          ERR       <= 1'b0;
          REQ_READY <= 1'b1;
          BUSY      <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
